mod_counter_gen: RTL
====================

// Module: mod_counter_gen
// PURPOSE
//   Parametrised modulo counter: up/down, runtime limit, wrap or saturate policy, load/clear.
//   General replacement for fixed 4-bit wrap counters in timer and sequencer datapaths.
//   count has exactly one driving process. No side path may ever modify it.
// PARAMETERS
//   WIDTH         8  count, limit and load_val width (>=2)
//   SATURATE      0  0 = wrap at terminal value, 1 = hold at terminal value
//   PRESCALE_DIV  4  enabled cycles per step (>=2); only used with MOD_COUNTER_PRESCALE_EN
// PORTS
//   clk       in   1      single clock, all logic on posedge
//   rst       in   1      synchronous, active-high reset
//   enable    in   1      step request for this cycle
//   clear     in   1      sync clear: count->0, flags/prescaler cleared
//   load      in   1      load count from load_val
//   load_val  in   WIDTH  load value
//   dir       in   1      1 = count up, 0 = count down
//   limit     in   WIDTH  terminal value; count range is 0..limit inclusive
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, 1 cycle)
//   wrapped   out  1      sticky: a terminal step has occurred since rst/clear
// BEHAVIOUR
//   Reset values: count=0, tc=0, wrapped=0, prescaler=0.
//   Priority per edge: rst > clear > load > step. Lower-priority requests in that cycle are dropped.
//   clear: count=0, tc=0, wrapped=0.
//   load: count=min(load_val, limit). tc=0. wrapped unchanged.
//   Step: occurs when enable=1 and no rst/clear/load. With the macro, the prescale tick must also be present.
//   Up step, count<limit: count+1, tc=0.
//   Up step, count>=limit (terminal): wrap mode -> count=0; saturate -> count=limit.
//     tc=1 and wrapped=1 in both policies.
//   Down step, count>0 and count<=limit: count-1, tc=0.
//   Down step, count==0 (terminal): wrap mode -> count=limit; saturate -> count=0.
//     tc=1 and wrapped=1 in both policies.
//   Down step, count>limit (limit lowered mid-run): count=limit, tc=0.
//   limit==0: count stays 0. Every step is terminal, so tc=1 on every step.
//   Latency: count, tc and wrapped update on the same edge as the step. tc is high for exactly that
//     following cycle. Without a new terminal step, tc=0 next cycle.
//   Non-step cycles: count holds, tc=0.
//   dir and limit are sampled every cycle, with no pipeline. A dir change takes effect on the next step.
//   All arithmetic is unsigned WIDTH-bit. No intermediate value may escape the 0..limit range.
// CONFIGURATION
//   MOD_COUNTER_PRESCALE_EN defined:
//     - Internal prescaler of $clog2(PRESCALE_DIV) bits advances on each enabled cycle.
//     - A step fires on every PRESCALE_DIV-th enabled cycle, i.e. when the prescaler reaches
//       PRESCALE_DIV-1; the prescaler then returns to 0.
//     - rst, clear and load zero the prescaler.
//     - enable=0 freezes the prescaler.
//   Not defined: no prescaler logic. Each enabled cycle is a step. PRESCALE_DIV is ignored.
// TESTING (WIDTH=4 unless noted)
//   1. rst=1 for 2 cycles mid-count (count=5) -> count=0, tc=0, wrapped=0 on the next edge.
//   2. limit=9, dir=1, SATURATE=0, enable held high from 0 for 10 steps:
//      count 1..9 then 0; tc high only the cycle count returns to 0; wrapped then stays 1.
//   3. limit=9, dir=0 from count=0, one step -> count=9, tc=1.
//      SATURATE=1 same stimulus -> count=0, tc=1, wrapped=1.
//   4. Same edge: clear=1, load=1 (load_val=7), enable=1 -> count=0, wrapped=0.
//      load=1, load_val=12, limit=9 -> count=9.
//   5. count=8, then limit set to 3:
//      dir=1 step -> count=0, tc=1; separately dir=0 step -> count=3, tc=0.
//      limit=0 with enable high -> count=0, tc=1 every cycle.
//   6. MOD_COUNTER_PRESCALE_EN, PRESCALE_DIV=4, enable high 12 cycles from 0 -> count=3;
//      load mid-run restarts the 4-cycle spacing; enable low pauses it without loss.

Source files
------------

// File: rtl/mod_counter_gen.sv
// ---------------------------------------------------------------------------
// mod_counter_gen
//   Parametrised modulo counter for timer and sequencer datapaths.
//   Counts up or down within 0..limit (inclusive), with either a wrap or a
//   saturate policy at the terminal value, plus synchronous clear and load.
//
// Parameters
//   WIDTH         count / limit / load_val width (>= 2)
//   SATURATE      0 = wrap at terminal value, 1 = hold at terminal value
//   PRESCALE_DIV  enabled cycles per step (>= 2), used only when the
//                 MOD_COUNTER_PRESCALE_EN macro is defined
//
// Optional feature
//   MOD_COUNTER_PRESCALE_EN : when defined, an internal prescaler makes a
//   step fire only on every PRESCALE_DIV-th enabled cycle. When undefined,
//   every enabled cycle is a step and no prescaler logic exists.
//
// Ports
//   clk       in   1      clock, all logic on posedge
//   rst       in   1      synchronous active-high reset
//   enable    in   1      step request for this cycle
//   clear     in   1      synchronous clear (count, flags, prescaler)
//   load      in   1      load count from load_val (clamped to limit)
//   load_val  in   WIDTH  load value
//   dir       in   1      1 = count up, 0 = count down
//   limit     in   WIDTH  terminal value
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, one cycle)
//   wrapped   out  1      sticky terminal-step flag since rst/clear
// ---------------------------------------------------------------------------
module mod_counter_gen #(
  parameter int WIDTH        = 8,
  parameter int SATURATE     = 0,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("mod_counter_gen: WIDTH must be >= 2");
  end
  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("mod_counter_gen: PRESCALE_DIV must be >= 2");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_wrapped_nxt;
  logic             w_step;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int               PS_W    = $clog2(PRESCALE_DIV);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0] r_presc;
  logic            w_tick;

  assign w_tick = (r_presc == PS_LAST);

  // Prescaler: advances on enabled cycles, restarts on rst/clear/load and
  // after each tick, freezes while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (clear || load) begin
      r_presc <= '0;
    end else if (enable) begin
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PS_W'(1);
      end
    end else begin
      r_presc <= r_presc;
    end
  end

  assign w_step = enable & ~clear & ~load & w_tick;
`else
  assign w_step = enable & ~clear & ~load;
`endif

  // Next-state computation for count, tc and the sticky wrapped flag.
  // Priority below rst: clear > load > step; lower requests are dropped.
  always_comb begin
    w_count_nxt   = r_count;
    w_tc_nxt      = 1'b0;
    w_wrapped_nxt = r_wrapped;
    if (clear) begin
      w_count_nxt   = '0;
      w_wrapped_nxt = 1'b0;
    end else if (load) begin
      // Load is clamped so count never leaves 0..limit.
      w_count_nxt = (load_val > limit) ? limit : load_val;
    end else if (w_step) begin
      if (dir) begin
        // count >= limit also covers a count stranded above a lowered limit.
        if (r_count >= limit) begin
          w_count_nxt   = (SATURATE != 0) ? limit : '0;
          w_tc_nxt      = 1'b1;
          w_wrapped_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        if (r_count > limit) begin
          // Limit was lowered under a running count: snap to it, no pulse.
          w_count_nxt = limit;
        end else if (r_count == '0) begin
          w_count_nxt   = (SATURATE != 0) ? '0 : limit;
          w_tc_nxt      = 1'b1;
          w_wrapped_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // State registers: the only process that drives count, tc and wrapped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_tc      <= w_tc_nxt;
      r_wrapped <= w_wrapped_nxt;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign wrapped = r_wrapped;

endmodule
